// File: rtl/mc_alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: op encodings, FSM states, flag positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpSlt   = 4'd5,
    OpSll   = 4'd6,
    OpSrl   = 4'd7,
    OpSra   = 4'd8,
    OpMul   = 4'd9,
    OpMulhu = 4'd10,
    OpDivu  = 4'd11,
    OpRemu  = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } alu_state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic is_mul_op(alu_op_t op);
    return (op == OpMul) || (op == OpMulhu);
  endfunction

  function automatic logic is_div_op(alu_op_t op);
    return (op == OpDivu) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/mc_alu_if.sv
// Start/ready/valid request and result bus of the multi-cycle ALU.
interface mc_alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) ();

  logic             start;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, op, a, b,
    input  ready, valid, result, flags
  );

  modport slave (
    input  start, op, a, b,
    output ready, valid, result, flags
  );

endinterface

// File: rtl/mc_alu_iter.sv
// Shared iterative datapath: right-shift shift-add multiply or restoring divide, one bit per step.
module mc_alu_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               div_q, div_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: acc = {remainder, dividend}; shift left, subtract divisor if it fits.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = rem_sh >= {1'b0, opnd_q};
    rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    div_next = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    if (load_i) begin
      div_d  = div_i;
      acc_d  = {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
      opnd_d = div_i ? b_i : a_i;
      cnt_d  = '0;
    end else if (step_i) begin
      acc_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  // Done and halves reflect the step taking effect this cycle so the top can register them now.
  assign done_o = step_i && (cnt_q == CntW'(WIDTH - 1));
  assign lo_o   = acc_d[WIDTH-1:0];
  assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL/MULHU/DIVU/REMU, NZCV flags.
module mc_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic    clk_i,
  input  logic    reset_ni,
  mc_alu_if.slave bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;

  logic             accept, multi, ready;
  logic             iter_load, iter_step, iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res, mc_res;
  logic             sc_c, sc_v;

  assign accept = bus.start && ready;
  // Divide by zero never enters the iterative path.
  assign multi  = is_mul_op(bus.op) || (is_div_op(bus.op) && (bus.b != '0));
  assign shamt  = bus.b[ShW-1:0];

  always_comb begin
    sub    = (bus.op == OpSub);
    b_x    = bus.b ^ {WIDTH{sub}};
    sum    = {1'b0, bus.a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op)
      OpAdd, OpSub: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = ~(bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ sub) & (bus.a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OpAnd:   sc_res = bus.a & bus.b;
      OpOr:    sc_res = bus.a | bus.b;
      OpXor:   sc_res = bus.a ^ bus.b;
      OpSlt:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OpSll:   sc_res = bus.a << shamt;
      OpSrl:   sc_res = bus.a >> shamt;
      OpSra:   sc_res = $unsigned($signed(bus.a) >>> shamt);
      OpDivu:  sc_res = '1;
      OpRemu:  sc_res = bus.a;
      default: sc_res = '0;
    endcase
  end

  mc_alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk_i  (clk_i),
    .rst_ni (reset_ni),
    .load_i (iter_load),
    .step_i (iter_step),
    .div_i  (is_div_op(bus.op)),
    .a_i    (bus.a),
    .b_i    (bus.b),
    .done_o (iter_done),
    .lo_o   (iter_lo),
    .hi_o   (iter_hi)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && multi) begin
          state_d = is_div_op(bus.op) ? StDiv : StMul;
        end
      end
      StMul, StDiv: begin
        if (iter_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready     = (state_q == StIdle);
    iter_load = accept && multi;
    iter_step = (state_q == StMul) || (state_q == StDiv);
  end

  assign mc_res = ((op_q == OpMul) || (op_q == OpDivu)) ? iter_lo : iter_hi;

  always_comb begin
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    if (accept) begin
      op_d = bus.op;
      if (!multi) begin
        result_d        = sc_res;
        flags_d[FLAG_N] = sc_res[WIDTH-1];
        flags_d[FLAG_Z] = (sc_res == '0);
        flags_d[FLAG_C] = sc_c;
        flags_d[FLAG_V] = sc_v;
        valid_d         = 1'b1;
      end
    end else if (iter_done) begin
      result_d        = mc_res;
      flags_d[FLAG_N] = mc_res[WIDTH-1];
      flags_d[FLAG_Z] = (mc_res == '0);
      flags_d[FLAG_C] = 1'b0;
      flags_d[FLAG_V] = 1'b0;
      valid_d         = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q     <= OpAdd;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready  = ready;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_mc_alu.sv
// Directed plus randomized checks of mc_alu (WIDTH 64 and 32) against an arithmetic reference model.
module tb_mc_alu;
  import alu_pkg::*;

  logic clk;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;

  mc_alu_if #(.WIDTH(64)) bus64 ();
  mc_alu_if #(.WIDTH(32)) bus32 ();

  mc_alu #(.WIDTH(64)) u_dut64 (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus64)
  );

  mc_alu #(.WIDTH(32)) u_dut32 (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit operands, 128-bit product.
  function automatic void model(input int op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic [3:0] f, output int lat);
    logic [64:0]  s;
    logic [127:0] p;
    logic         c, v;
    c   = 1'b0;
    v   = 1'b0;
    lat = 0;
    p   = {64'd0, a} * {64'd0, b};
    s   = {1'b0, a} + {1'b0, b};
    case (op)
      0: begin
        r = s[63:0];
        c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      1: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      6: r = a << b[5:0];
      7: r = a >> b[5:0];
      8: r = $unsigned($signed(a) >>> b[5:0]);
      9: begin r = p[63:0]; lat = 64; end
      10: begin r = p[127:64]; lat = 64; end
      11: if (b == 0) r = '1; else begin r = a / b; lat = 64; end
      12: if (b == 0) r = a; else begin r = a % b; lat = 64; end
      default: r = '0;
    endcase
    f = {r[63], (r == 64'd0), c, v};
  endfunction

  task automatic run64(input int op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] er;
    logic [3:0]  ef;
    int          lat;
    int          busy;
    model(op, a, b, er, ef, lat);
    @(negedge clk);
    chk("ready_idle", 64'(bus64.ready), 64'd1);
    bus64.start = 1'b1;
    bus64.op    = alu_op_t'(4'(op));
    bus64.a     = a;
    bus64.b     = b;
    @(posedge clk);
    #1;
    bus64.start = 1'b0;
    bus64.a     = {$urandom(), $urandom()};
    bus64.b     = {$urandom(), $urandom()};
    @(negedge clk);
    busy = 0;
    while (!bus64.valid && busy < 80) begin
      chk("busy_ready", 64'(bus64.ready), 64'd0);
      busy++;
      // Requests while busy must be dropped.
      bus64.start = 1'($urandom_range(0, 1));
      bus64.op    = alu_op_t'(4'($urandom_range(0, 15)));
      bus64.a     = {$urandom(), $urandom()};
      bus64.b     = {$urandom(), $urandom()};
      @(negedge clk);
    end
    bus64.start = 1'b0;
    chk("latency", 64'(busy), 64'(lat));
    chk("valid", 64'(bus64.valid), 64'd1);
    chk("ready_done", 64'(bus64.ready), 64'd1);
    chk("result", bus64.result, er);
    chk("flags", 64'(bus64.flags), 64'(ef));
    @(negedge clk);
    chk("valid_pulse", 64'(bus64.valid), 64'd0);
    chk("result_hold", bus64.result, er);
  endtask

  // Two single-cycle ops accepted on consecutive edges.
  task automatic pair(input int op1, input logic [63:0] a1, input logic [63:0] b1,
                      input int op2, input logic [63:0] a2, input logic [63:0] b2);
    logic [63:0] r1, r2;
    logic [3:0]  f1, f2;
    int          l1, l2;
    model(op1, a1, b1, r1, f1, l1);
    model(op2, a2, b2, r2, f2, l2);
    @(negedge clk);
    bus64.start = 1'b1;
    bus64.op    = alu_op_t'(4'(op1));
    bus64.a     = a1;
    bus64.b     = b1;
    @(posedge clk);
    #1;
    bus64.op = alu_op_t'(4'(op2));
    bus64.a  = a2;
    bus64.b  = b2;
    @(negedge clk);
    chk("pair_valid1", 64'(bus64.valid), 64'd1);
    chk("pair_ready1", 64'(bus64.ready), 64'd1);
    chk("pair_result1", bus64.result, r1);
    chk("pair_flags1", 64'(bus64.flags), 64'(f1));
    @(posedge clk);
    #1;
    bus64.start = 1'b0;
    @(negedge clk);
    chk("pair_valid2", 64'(bus64.valid), 64'd1);
    chk("pair_result2", bus64.result, r2);
    chk("pair_flags2", 64'(bus64.flags), 64'(f2));
    @(negedge clk);
    chk("pair_valid_end", 64'(bus64.valid), 64'd0);
  endtask

  task automatic run32(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int lat);
    int busy;
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.op    = alu_op_t'(4'(op));
    bus32.a     = a;
    bus32.b     = b;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    @(negedge clk);
    busy = 0;
    while (!bus32.valid && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    chk("w32_latency", 64'(busy), 64'(lat));
    chk("w32_result", 64'(bus32.result), 64'(er));
    chk("w32_flags", 64'(bus32.flags), 64'(ef));
  endtask

  initial begin
    int          pulses;
    int          o;
    logic [63:0] ra, rb;

    reset_n     = 1'b0;
    bus64.start = 1'b0;
    bus64.op    = OpAdd;
    bus64.a     = '0;
    bus64.b     = '0;
    bus32.start = 1'b0;
    bus32.op    = OpAdd;
    bus32.a     = '0;
    bus32.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus64.result, 64'd0);
    chk("rst_flags", 64'(bus64.flags), 64'd0);
    chk("rst_valid", 64'(bus64.valid), 64'd0);
    chk("rst_ready", 64'(bus64.ready), 64'd1);
    reset_n = 1'b1;

    run64(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    pair(1, 64'd5, 64'd5, 5, '1, 64'd1);
    run64(9, '1, 64'd2);
    run64(10, '1, 64'd2);
    run64(11, 64'd100, 64'd7);
    run64(12, 64'd100, 64'd7);
    run64(11, 64'h1234_5678_9ABC_DEF0, 64'd0);
    run64(12, 64'd9, 64'd0);
    run64(14, 64'd3, 64'd4);

    // Abort a multiply with reset: nothing may complete and the held result clears.
    @(negedge clk);
    bus64.start = 1'b1;
    bus64.op    = OpMul;
    bus64.a     = 64'd77;
    bus64.b     = 64'd55;
    @(posedge clk);
    #1;
    bus64.start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_result", bus64.result, 64'd0);
    chk("abort_flags", 64'(bus64.flags), 64'd0);
    chk("abort_ready", 64'(bus64.ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus64.valid) pulses++;
    end
    chk("abort_no_valid", 64'(pulses), 64'd0);
    chk("abort_ready_after", 64'(bus64.ready), 64'd1);
    run64(0, 64'd2, 64'd3);

    run32(8, 32'h8000_0000, 32'h21, 32'hC000_0000, 4'b1000, 0);
    run32(6, 32'd1, 32'd31, 32'h8000_0000, 4'b1000, 0);
    run32(9, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 4'b1000, 32);
    run32(11, 32'd100, 32'd7, 32'd14, 4'b0000, 32);

    for (int i = 0; i < 30; i++) begin
      ra = {$urandom(), $urandom()};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom(), $urandom()};
      o  = $urandom_range(0, 15);
      run64(o, ra, rb);
    end
    for (int i = 0; i < 15; i++) begin
      o  = $urandom_range(0, 15);
      rb = {$urandom(), $urandom()};
      // Keep both ops single-cycle: divides only by zero.
      if (o >= 9 && o <= 12) begin
        o  = 11 + (o % 2);
        rb = '0;
      end
      pair(o, {$urandom(), $urandom()}, rb, $urandom_range(0, 8),
           {$urandom(), $urandom()}, {$urandom(), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
# mc_alu

Parametrised multi-cycle ALU for the multi-cycle RISC-V core's execute stage. It extends the single-cycle add/sub/and/or ALU with XOR, set-less-than, shifts, and iterative unsigned multiply/divide. Results and NZCV flags are registered and delivered over a start/ready/valid handshake. The controller FSM starts an operation and waits for `valid` before writeback.

## Interface
- `WIDTH`, default 64: operand/result width; must be a power of two, at least 8.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `start && ready`.
- `op`  in  4  `alu_op_t`; sampled at accept.
- `a`, `b`  in  WIDTH each  operands; sampled at accept, may change afterwards.
- `ready`  out  1  high when a new op can be accepted.
- `valid`  out  1  one-cycle pulse; `result`/`flags` are new this cycle.
- `result`  out  WIDTH  holds the last completed result until the next completion.
- `flags`  out  4  `{N,Z,C,V}`; holds with `result`.

## Operation
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1/0), 6 SLL, 7 SRL, 8 SRA.
  - 9 MUL (low WIDTH bits of the unsigned product), 10 MULHU (high WIDTH bits), 11 DIVU, 12 REMU.
  - 13–15 reserved: result 0, flags computed normally from that result.
- Shift amount is `b[$clog2(WIDTH)-1:0]`; upper bits of `b` are ignored.
- ADD/SUB: WIDTH+1-bit sum `a + (b ^ {WIDTH{sub}}) + sub`.
  - C = bit WIDTH of the sum.
  - V = `~(a[W-1]^b[W-1]^sub) & (a[W-1]^sum[W-1])`.
- C and V are 0 for all other ops.
- N = `result[W-1]` and Z = (`result == 0`) for every op.
- FSM states:
  - IDLE: `ready=1`. On accept of ops 0–8 or 13–15, compute and register the result; stay in IDLE.
  - IDLE, accept of 9/10: go to MUL. Accept of 11/12: go to DIV, unless `b==0`.
  - MUL: shift-add, one bit per cycle, count = WIDTH. After the last iteration, register the result and return to IDLE.
  - DIV: restoring division, one quotient bit per cycle, count = WIDTH. After the last iteration, register the quotient (DIVU) or remainder (REMU) and return to IDLE.
- Divide by zero is single-cycle: DIVU returns all-ones, REMU returns `a`. No fault indication.
- `start` while `ready=0` is ignored and never queued.
- Reset: state IDLE, `result=0`, `flags=0`, `valid=0`, iteration counter 0, `ready=1`.
- Reset asserted mid-operation aborts it: no `valid`, and the held `result` is cleared to 0.

## Timing
- Single-cycle op accepted at edge T: `result`/`flags`/`valid` are updated at T+1.
- Back-to-back single-cycle ops sustain one result per cycle, because `ready` stays high.
- Multi-cycle op accepted at T:
  - `ready=0` for cycles T+1..T+WIDTH.
  - `valid=1` and `ready=1` in cycle T+WIDTH+1.
  - A new op can be accepted in that same cycle.
- `valid` is never high for two consecutive cycles for the same op.
- `valid` is high on consecutive cycles only for back-to-back single-cycle accepts.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_t` enum with the encodings above.
  - `alu_state_t` (IDLE/MUL/DIV).
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
- One sub-module `mc_alu_iter` (parameter WIDTH) holds the shared iterative datapath:
  - Registers: accumulator (2·WIDTH), operand shift register, counter.
  - Modes: multiply or divide.
  - Control: load/step strobes from the top-level FSM.
  - Outputs: done, low half, high half.
- Top level holds the FSM, the single-cycle combinational path, and the output registers.

## Test plan
- Reset mid-MUL, then release: `valid` never pulses, `result=0`, `ready=1`; a following ADD 2+3 yields 5.
- WIDTH=64, ADD `a=0x7FFF_FFFF_FFFF_FFFF`, `b=1` -> `result=0x8000_0000_0000_0000`, flags=1001 (N,V), `valid` at T+1.
- SUB 5−5 -> result 0, flags=0110 (Z,C). Immediately followed by SLT `a=-1`, `b=1` -> result 1 on the next cycle.
- MUL `a=0xFFFF_FFFF_FFFF_FFFF`, `b=2` -> `result=0xFFFF_FFFF_FFFF_FFFE`. Then MULHU with the same operands -> 1.
  - For both: `ready` is low exactly 64 cycles, `valid` at T+65, and `start` pulses during busy are ignored.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2, each at T+65. DIVU x/0 -> all-ones at T+1; REMU 9/0 -> 9 at T+1.
- WIDTH=32: SRA `0x8000_0000` by `b=0x21` (amount 1) -> `0xC000_0000`, N=1. SLL by 31 of 1 -> `0x8000_0000`.
